// File: rtl/axi_gpio_mch.sv
// Multi-channel AXI4-Lite GPIO: NUM_CH channels of DATA/TRI registers, byte strobes,
// 2-flop input synchronisers and per-channel change-detect interrupts.
module axi_gpio_mch #(
  parameter int          NUM_CH       = 2,
  parameter int          CH_WIDTH     = 32,
  parameter logic [31:0] DOUT_DEFAULT = 32'h0000_0000,
  parameter logic [31:0] TRI_DEFAULT  = 32'hFFFF_FFFF
) (
  input  logic                         s_axi_aclk,
  input  logic                         s_axi_areset,
  input  logic [8:0]                   s_axi_awaddr,
  input  logic                         s_axi_awvalid,
  output logic                         s_axi_awready,
  input  logic [31:0]                  s_axi_wdata,
  input  logic [3:0]                   s_axi_wstrb,
  input  logic                         s_axi_wvalid,
  output logic                         s_axi_wready,
  output logic [1:0]                   s_axi_bresp,
  output logic                         s_axi_bvalid,
  input  logic                         s_axi_bready,
  input  logic [8:0]                   s_axi_araddr,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  output logic [31:0]                  s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  input  logic [NUM_CH*CH_WIDTH-1:0]   gpio_io_i,
  output logic [NUM_CH*CH_WIDTH-1:0]   gpio_io_o,
  output logic [NUM_CH*CH_WIDTH-1:0]   gpio_io_t,
  output logic                         ip2intc_irpt
);

  localparam int GW = NUM_CH * CH_WIDTH;
  localparam logic [6:0] GIER_W  = 7'h47;
  localparam logic [6:0] IPISR_W = 7'h48;
  localparam logic [6:0] IPIER_W = 7'h4A;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t          w_state_reg;
  r_state_t          r_state_reg;
  logic [6:0]        aw_addr_reg;
  logic [31:0]       w_data_reg;
  logic [3:0]        w_strb_reg;
  logic              awready_reg, wready_reg, bvalid_reg, arready_reg, rvalid_reg;
  logic [1:0]        bresp_reg, rresp_reg;
  logic [31:0]       rdata_reg;

  logic [GW-1:0]     sync1_reg, sync2_reg, prev_reg;
  logic [GW-1:0]     data_rd;
  logic [NUM_CH-1:0] ch_event;
  logic              gier_reg, irpt_reg;
  logic [NUM_CH-1:0] ipier_reg, ipisr_reg, ipisr_toggle;

  logic              aw_hs, w_hs, wr_fire, wr_ch_ok, wr_mapped;
  logic [6:0]        wr_addr, rd_addr;
  logic [31:0]       wr_data, wr_mask, rd_data;
  logic [3:0]        wr_strb;
  logic              rd_err;
  logic              unused_addr_lsbs;

  assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign s_axi_awready = awready_reg;
  assign s_axi_wready  = wready_reg;
  assign s_axi_bvalid  = bvalid_reg;
  assign s_axi_bresp   = bresp_reg;
  assign s_axi_arready = arready_reg;
  assign s_axi_rvalid  = rvalid_reg;
  assign s_axi_rresp   = rresp_reg;
  assign s_axi_rdata   = rdata_reg;
  assign ip2intc_irpt  = irpt_reg;

  assign aw_hs = s_axi_awvalid & awready_reg;
  assign w_hs  = s_axi_wvalid & wready_reg;

  // Effective write beat: whichever half arrives last is taken live from the bus.
  always_comb begin
    wr_fire = 1'b0;
    wr_addr = aw_addr_reg;
    wr_data = w_data_reg;
    wr_strb = w_strb_reg;
    case (w_state_reg)
      W_IDLE: begin
        wr_fire = aw_hs & w_hs;
        wr_addr = s_axi_awaddr[8:2];
        wr_data = s_axi_wdata;
        wr_strb = s_axi_wstrb;
      end
      W_HAVE_A: begin
        wr_fire = w_hs;
        wr_data = s_axi_wdata;
        wr_strb = s_axi_wstrb;
      end
      W_HAVE_D: begin
        wr_fire = aw_hs;
        wr_addr = s_axi_awaddr[8:2];
      end
      default: ;
    endcase
  end

  assign wr_ch_ok  = (wr_addr[6:4] == 3'd0) && (int'(wr_addr[3:1]) < NUM_CH);
  assign wr_mapped = wr_ch_ok || (wr_addr == GIER_W) || (wr_addr == IPISR_W) || (wr_addr == IPIER_W);
  assign wr_mask   = {{8{wr_strb[3]}}, {8{wr_strb[2]}}, {8{wr_strb[1]}}, {8{wr_strb[0]}}};

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      w_state_reg <= W_IDLE;
      awready_reg <= 1'b0;
      wready_reg  <= 1'b0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= 2'b00;
      aw_addr_reg <= '0;
      w_data_reg  <= '0;
      w_strb_reg  <= '0;
    end else begin
      case (w_state_reg)
        W_IDLE: begin
          awready_reg <= 1'b1;
          wready_reg  <= 1'b1;
          if (aw_hs && w_hs) begin
            w_state_reg <= W_RESP;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            bvalid_reg  <= 1'b1;
            bresp_reg   <= wr_mapped ? 2'b00 : 2'b10;
          end else if (aw_hs) begin
            w_state_reg <= W_HAVE_A;
            aw_addr_reg <= s_axi_awaddr[8:2];
            awready_reg <= 1'b0;
          end else if (w_hs) begin
            w_state_reg <= W_HAVE_D;
            w_data_reg  <= s_axi_wdata;
            w_strb_reg  <= s_axi_wstrb;
            wready_reg  <= 1'b0;
          end
        end
        W_HAVE_A, W_HAVE_D: begin
          if (wr_fire) begin
            w_state_reg <= W_RESP;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            bvalid_reg  <= 1'b1;
            bresp_reg   <= wr_mapped ? 2'b00 : 2'b10;
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            w_state_reg <= W_IDLE;
            bvalid_reg  <= 1'b0;
            awready_reg <= 1'b1;
            wready_reg  <= 1'b1;
          end
        end
        default: w_state_reg <= W_IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : gen_ch
    logic [CH_WIDTH-1:0] dout_reg, tri_reg, cw_mask, cw_data;
    logic                hit_dout, hit_tri;

    assign cw_mask  = wr_mask[CH_WIDTH-1:0];
    assign cw_data  = wr_data[CH_WIDTH-1:0];
    assign hit_dout = wr_fire && wr_ch_ok && (wr_addr[3:1] == 3'(gi)) && !wr_addr[0];
    assign hit_tri  = wr_fire && wr_ch_ok && (wr_addr[3:1] == 3'(gi)) &&  wr_addr[0];

    always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
        dout_reg <= DOUT_DEFAULT[CH_WIDTH-1:0];
        tri_reg  <= TRI_DEFAULT[CH_WIDTH-1:0];
      end else begin
        if (hit_dout) dout_reg <= (dout_reg & ~cw_mask) | (cw_data & cw_mask);
        if (hit_tri)  tri_reg  <= (tri_reg & ~cw_mask) | (cw_data & cw_mask);
      end
    end

    assign gpio_io_o[gi*CH_WIDTH +: CH_WIDTH] = dout_reg;
    assign gpio_io_t[gi*CH_WIDTH +: CH_WIDTH] = tri_reg;
    // Inputs read back only where the pin is tri-stated; driven pins echo the output register.
    assign data_rd[gi*CH_WIDTH +: CH_WIDTH] =
        (tri_reg & sync2_reg[gi*CH_WIDTH +: CH_WIDTH]) | (~tri_reg & dout_reg);
    assign ch_event[gi] =
        |((sync2_reg[gi*CH_WIDTH +: CH_WIDTH] ^ prev_reg[gi*CH_WIDTH +: CH_WIDTH]) & tri_reg);
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      prev_reg  <= '0;
    end else begin
      sync1_reg <= gpio_io_i;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  assign ipisr_toggle = (wr_fire && (wr_addr == IPISR_W) && wr_strb[0]) ? wr_data[NUM_CH-1:0] : '0;

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      gier_reg  <= 1'b0;
      ipier_reg <= '0;
      ipisr_reg <= '0;
      irpt_reg  <= 1'b0;
    end else begin
      if (wr_fire && (wr_addr == GIER_W) && wr_strb[3]) gier_reg <= wr_data[31];
      if (wr_fire && (wr_addr == IPIER_W) && wr_strb[0]) ipier_reg <= wr_data[NUM_CH-1:0];
      // OR-ing the event after the toggle lets a same-cycle event win over a clear.
      ipisr_reg <= (ipisr_reg ^ ipisr_toggle) | ch_event;
      irpt_reg  <= gier_reg & |(ipisr_reg & ipier_reg);
    end
  end

  assign rd_addr = s_axi_araddr[8:2];

  always_comb begin
    rd_data = 32'h0;
    rd_err  = 1'b0;
    if (rd_addr[6:4] == 3'd0) begin
      if (int'(rd_addr[3:1]) < NUM_CH) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (int'(rd_addr[3:1]) == c)
            rd_data = rd_addr[0] ? 32'(gpio_io_t[c*CH_WIDTH +: CH_WIDTH])
                                 : 32'(data_rd[c*CH_WIDTH +: CH_WIDTH]);
        end
      end else begin
        rd_err = 1'b1;
      end
    end else begin
      case (rd_addr)
        GIER_W:  rd_data = {gier_reg, 31'h0};
        IPISR_W: rd_data = 32'(ipisr_reg);
        IPIER_W: rd_data = 32'(ipier_reg);
        default: rd_err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_state_reg <= R_IDLE;
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rdata_reg   <= 32'h0;
      rresp_reg   <= 2'b00;
    end else begin
      case (r_state_reg)
        R_IDLE: begin
          arready_reg <= 1'b1;
          if (s_axi_arvalid && arready_reg) begin
            r_state_reg <= R_DATA;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b1;
            rdata_reg   <= rd_data;
            rresp_reg   <= rd_err ? 2'b10 : 2'b00;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            r_state_reg <= R_IDLE;
            rvalid_reg  <= 1'b0;
            arready_reg <= 1'b1;
          end
        end
        default: r_state_reg <= R_IDLE;
      endcase
    end
  end

endmodule
